design239_channel_mixer: RTL and testbench



---
 rtl/design239_channel_mixer_pkg.sv | 38 +++
 rtl/design239_mix_channel.sv | 46 ++++
 rtl/design239_channel_mixer.sv | 61 ++++++
 tb/tb_design239_channel_mixer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/design239_channel_mixer_pkg.sv
//------------------------------------------------------------------------------
// design239_channel_mixer_pkg : shared constants and helpers for the mixer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package design239_channel_mixer_pkg;

    // Number of register stages between in_q and out that must fill before out is trusted.
    localparam int c_valid_depth = 3;

    function automatic int rot_amount(input int k, input int width);
        return (4 * k + 1) % width;
    endfunction

    // Full mixing function F for any legal width (up to 64 bits).
    function automatic logic [63:0] mix_word(input logic [63:0] x, input int width,
                                             input int channels);
        logic [63:0] mask;
        logic [63:0] xm;
        logic [63:0] a;
        logic [63:0] acc;
        int          r;
        mask = (width == 64) ? '1 : ((64'd1 << width) - 64'd1);
        xm   = x & mask;
        acc  = '0;
        for (int k = 0; k < channels; k++) begin
            r   = rot_amount(k, width);
            a   = (xm << r) | ((r == 0) ? 64'd0 : (xm >> (width - r)));
            a   = (a + 64'(k)) & mask;
            acc = acc ^ (a ^ (a >> 1));
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/design239_mix_channel.sv
//------------------------------------------------------------------------------
// design239_mix_channel : one channel, rotate+add stage then Gray-encode stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module design239_mix_channel
    import design239_channel_mixer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int c_rot = rot_amount(IDX, WIDTH);

    logic [WIDTH-1:0] w_rot;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    // A zero rotation cannot be expressed as a part-select, so it gets its own branch.
    if (c_rot == 0) begin : g_norot
        assign w_rot = din;
    end else begin : g_rot
        assign w_rot = {din[WIDTH-1-c_rot:0], din[WIDTH-1 -: c_rot]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= w_rot + WIDTH'(IDX);
            r_b <= r_a ^ (r_a >> 1);
        end
    end

    assign dout = r_b;

endmodule

`default_nettype wire

// File: rtl/design239_channel_mixer.sv
//------------------------------------------------------------------------------
// design239_channel_mixer : fan input to CHANNEL transforms, XOR-reduce to out
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module design239_channel_mixer
    import design239_channel_mixer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CHANNEL = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0]         r_in_q;
    logic [c_valid_depth-1:0] r_v;
    logic [WIDTH-1:0]         w_b [CHANNEL];
    logic [WIDTH-1:0]         w_mix;
    logic [WIDTH-1:0]         r_out;

    for (genvar k = 0; k < CHANNEL; k++) begin : g_chan
        design239_mix_channel #(
            .WIDTH (WIDTH),
            .IDX   (k)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .din  (r_in_q),
            .dout (w_b[k])
        );
    end

    always_comb begin
        w_mix = '0;
        for (int k = 0; k < CHANNEL; k++) begin
            w_mix = w_mix ^ w_b[k];
        end
    end

    // Output is gated by the fill tracker so the constant-k terms never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_q <= '0;
            r_v    <= '0;
            r_out  <= '0;
        end else begin
            r_in_q <= in;
            r_v    <= {r_v[c_valid_depth-2:0], 1'b1};
            r_out  <= r_v[c_valid_depth-1] ? w_mix : '0;
        end
    end

    assign out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_design239_channel_mixer.sv
//------------------------------------------------------------------------------
// tb_design239_channel_mixer : directed self-checking bench for the mixer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_design239_channel_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic [31:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural pipeline model: three tracked stages feeding the output.
    logic [31:0] m_w [3];
    logic        m_v [3];
    logic [31:0] m_out;

    design239_channel_mixer #(
        .WIDTH   (32),
        .CHANNEL (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_f(input logic [31:0] x);
        logic [63:0] dbl;
        logic [31:0] a;
        logic [31:0] acc;
        acc = '0;
        for (int k = 0; k < 5; k++) begin
            dbl = {x, x} << (4 * k + 1);
            a   = dbl[63:32] + 32'(k);
            acc = acc ^ a ^ {1'b0, a[31:1]};
        end
        return acc;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_w[i] = '0;
            m_v[i] = 1'b0;
        end
        m_out = '0;
    endtask

    // Advance one rising edge, update the model, sample 1 time unit later.
    task automatic tick();
        logic [31:0] sampled;
        sampled = din;
        @(posedge clk);
        m_out  = m_v[2] ? ref_f(m_w[2]) : 32'h0;
        m_w[2] = m_w[1]; m_v[2] = m_v[1];
        m_w[1] = m_w[0]; m_v[1] = m_v[0];
        m_w[0] = sampled; m_v[0] = 1'b1;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        int          nt;
        int          ph;

        model_reset();
        // Sanity of the bench model against the hand-derived reference values.
        check("ref_zero", ref_f(32'h0), 32'h0000_0006);
        check("ref_ones", ref_f(32'hFFFF_FFFF), 32'h8000_0000);

        // Power-up with in held at zero.
        din = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dout, 32'h0);
        #3 rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("fill_zero", dout, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("steady_zero", dout, 32'h0000_0006);
        end

        // Asynchronous reset, then all-ones input.
        #2 rst = 1'b1;
        #1 check("async_rst_a", dout, 32'h0);
        model_reset();
        din = 32'hFFFF_FFFF;
        tick();
        #2 rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("fill_ones", dout, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("steady_ones", dout, 32'h8000_0000);
        end

        // Long run then a single input change: switch exactly 4 edges later.
        din = 32'hABCD_EFAB;
        for (int i = 0; i < 50; i++) tick();
        check("hold_abcd", dout, ref_f(32'hABCD_EFAB));
        din = 32'h1234_5678;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("old_word_held", dout, ref_f(32'hABCD_EFAB));
        end
        tick();
        check("new_word", dout, ref_f(32'h1234_5678));
        check("new_word_model", dout, m_out);

        // Back-to-back alternating words.
        for (int i = 0; i < 12; i++) begin
            din = (i % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
            tick();
            check("alternate", dout, m_out);
        end
        din = 32'h0;
        tick();
        check("alt_tail_a", dout, 32'h8000_0000);
        tick();
        check("alt_tail_b", dout, 32'h0000_0006);

        // Mid-stream asynchronous reset with 0xAAAAAAAA.
        din = 32'hAAAA_AAAA;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_aa", dout, ref_f(32'hAAAA_AAAA));
        #3 rst = 1'b1;
        #1 check("async_rst_b", dout, 32'h0);
        model_reset();
        tick();
        check("held_in_rst", dout, 32'h0);
        #2 rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("refill_aa", dout, 32'h0);
        end
        tick();
        check("recover_aa", dout, ref_f(32'hAAAA_AAAA));

        // Repeated reset pulses at varying phases with varying data.
        for (int p = 0; p < 20; p++) begin
            nt = $urandom_range(2, 8);
            for (int i = 0; i < nt; i++) begin
                r   = $urandom;
                din = r;
                tick();
                check("pulse_run", dout, m_out);
            end
            ph = $urandom_range(1, 7);
            #(ph) rst = 1'b1;
            #1 check("pulse_rst", dout, 32'h0);
            model_reset();
            #9 rst = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            r   = $urandom;
            din = r;
            tick();
            check("pulse_final", dout, m_out);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
